// File: rtl/rv32i_types.sv
// Base RV32I scalar types shared across the core.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

endpackage

// File: rtl/tomasula_types.sv
// Front-end types: fetch buffer entry, fetch FSM encoding and reset PC.
package tomasula_types;

  import rv32i_types::*;

  localparam rv32i_word PC_RESET_DEFAULT = 32'h0000_0060;

  typedef struct packed {
    rv32i_word pc;
    rv32i_word instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: circular queue of {pc, instr} entries with a synchronous
// flush that empties it. The head is read straight out of the storage flops.
module fetch_fifo
  import tomasula_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_en, pop_en;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  // flush wins over both push and pop; a push into a full buffer is dropped
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;

  // write the incoming entry at the tail slot
  always_comb begin
    mem_d = mem_q;
    if (push_en) mem_d[wr_ptr_q] = push_entry;
  end

  // pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // entry storage needs no reset: occupancy alone decides validity
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // control state with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, fills the
// fetch buffer sequentially and redirects on flush.
//
//   state | meaning
//   IDLE  | no request outstanding (buffer full, or just out of reset)
//   REQ   | request outstanding, its data will be pushed
//   DRAIN | request outstanding from before a flush, its data is dropped
module ifetch_unit
  import rv32i_types::*, tomasula_types::*;
#(
  parameter int        IQ_DEPTH = 4,
  parameter rv32i_word PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        instr_read,
  output logic [31:0] instr_mem_address,
  input  logic        instr_mem_resp,
  input  logic [31:0] instr_mem_rdata,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        iq_pop,
  output logic        iq_valid,
  output logic [31:0] iq_instr,
  output logic [31:0] iq_pc,
  output logic        iq_full
);

  localparam int CW = $clog2(IQ_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(IQ_DEPTH - 1);

  fetch_state_t  state_q, state_d;
  rv32i_word     pc_q, pc_d;
  rv32i_word     drain_addr_q, drain_addr_d;

  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          resp_take, pop_take, fills_up;

  assign resp_take  = (state_q == REQ) && instr_mem_resp && !flush;
  assign pop_take   = iq_pop && iq_valid;
  // this push lands in the last free slot and no pop frees one
  assign fills_up   = (fifo_count == CNT_LAST) && !pop_take;
  assign push_entry = '{pc: pc_q, instr: instr_mem_rdata};

  assign iq_valid = !fifo_empty;
  assign iq_full  = fifo_full;
  assign iq_pc    = head_entry.pc;
  assign iq_instr = head_entry.instr;

  fetch_fifo #(.DEPTH(IQ_DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (resp_take),
    .push_entry (push_entry),
    .pop        (iq_pop),
    .flush      (flush),
    .head       (head_entry),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state: flush redirects, otherwise fetch until the buffer is full
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (flush || !fifo_full) state_d = REQ;
      end
      REQ: begin
        if (flush)               state_d = instr_mem_resp ? REQ : DRAIN;
        else if (instr_mem_resp) state_d = fills_up ? IDLE : REQ;
      end
      DRAIN: begin
        if (instr_mem_resp) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs: a drained request keeps presenting its original address
  always_comb begin
    instr_read        = 1'b0;
    instr_mem_address = pc_q;
    unique case (state_q)
      REQ:   instr_read = 1'b1;
      DRAIN: begin
        instr_read        = 1'b1;
        instr_mem_address = drain_addr_q;
      end
      default: instr_read = 1'b0;
    endcase
  end

  // PC and held drain address; flush overrides sequential advance
  always_comb begin
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    if (flush) begin
      pc_d = flush_pc;
      if ((state_q == REQ) && !instr_mem_resp) drain_addr_d = pc_q;
    end else if (resp_take) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= PC_RESET;
      drain_addr_q <= PC_RESET;
    end else begin
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Clocking SHALL be one clock, clk; reset_n SHALL be an asynchronous, active-low reset.
REQ-002 Parameter IQ_DEPTH, default 4: fetch buffer entries (power of two, at least 2).
REQ-003 Parameter PC_RESET, default 32'h00000060: first fetch address.
REQ-004 clk  in  1  system clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 instr_read  out  1  instruction memory read request.
REQ-007 instr_mem_address  out  32  fetch address (rv32i_word).
REQ-008 instr_mem_resp  in  1  one-cycle pulse; read data valid.
REQ-009 instr_mem_rdata  in  32  fetched instruction.
REQ-010 flush  in  1  redirect pulse from the ROB (mispredict or jump).
REQ-011 flush_pc  in  32  redirect target; valid when flush=1.
REQ-012 iq_pop  in  1  issue stage consumes the head entry this cycle.
REQ-013 iq_valid  out  1  head entry valid.
REQ-014 iq_instr  out  32  head instruction.
REQ-015 iq_pc  out  32  head PC.
REQ-016 iq_full  out  1  buffer holds IQ_DEPTH entries.

Function
REQ-017 FSM states SHALL be IDLE, REQ and DRAIN.
- IDLE: no request outstanding.
- REQ: request outstanding.
- DRAIN: outstanding request whose data is discarded.
REQ-018 IDLE -> REQ SHALL occur when the buffer count is below IQ_DEPTH and flush=0; instr_read is asserted combinationally in REQ and DRAIN only.
REQ-019 Request rules:
- instr_mem_address = fetch PC.
- instr_read and the address SHALL remain stable until instr_mem_resp.
- At most one request SHALL be outstanding.
REQ-020 REQ with resp=1 and flush=0:
- Push {PC, rdata} to the buffer.
- PC <= PC+4 (mod 2^32 wrap).
- Next state is REQ if the post-cycle count is below IQ_DEPTH, else IDLE.
- Back-to-back requests SHALL have zero idle cycles.
REQ-021 Pop rules:
- iq_pop with iq_valid=1 SHALL remove the head entry in the same cycle.
- iq_pop with an empty buffer SHALL be ignored.
- Simultaneous push and pop SHALL leave the count unchanged.
REQ-022 Full: a request SHALL never be issued while count equals IQ_DEPTH, so a push into a full buffer is impossible; iq_full = (count == IQ_DEPTH).
REQ-023 Flush has priority over push, pop and the FSM; in its cycle it SHALL:
- Empty the buffer, so iq_valid=0 next cycle.
- Set PC <= flush_pc.
REQ-024 Flush next state:
- In IDLE, or in REQ/DRAIN with resp=1 the same cycle: next state REQ at flush_pc; response data is discarded.
- In REQ with resp=0: next state DRAIN; instr_read and the old address are held.
REQ-025 DRAIN:
- On resp, discard data and go to REQ with the new PC.
- A further flush in DRAIN SHALL only update PC.
REQ-026 Buffer pointers SHALL be log2(IQ_DEPTH) bits and wrap modulo IQ_DEPTH; the count SHALL be log2(IQ_DEPTH)+1 bits.
REQ-027 iq_instr and iq_pc SHALL be driven from registered storage (no memory-to-issue combinational path); their value is don't-care when iq_valid=0.

Reset
REQ-028 On reset_n=0, asynchronously:
- State = IDLE, PC = PC_RESET, count and pointers = 0.
- instr_read=0, iq_valid=0, iq_full=0.
REQ-029 Reset mid-request SHALL abandon the request; a late instr_mem_resp arriving in IDLE SHALL be ignored.
REQ-030 The first request SHALL assert in the second clk edge window after reset_n deasserts (IDLE -> REQ on the first edge).

Structure
REQ-031 fetch_entry_t {pc, instr} and the default PC_RESET SHALL live in tomasula_types; rv32i_word comes from rv32i_types.
REQ-032 The buffer SHALL be a sub-module, fetch_fifo (push, pop, flush, full, empty, count); the FSM and PC SHALL stay in ifetch_unit.

Verification
REQ-033 Reset, then memory resp after 1 cycle, for 4 fetches with iq_pop=0:
- Addresses are 0x60, 0x64, 0x68, 0x6C.
- iq_full=1 and instr_read=0 afterwards.
- Head iq_pc=0x60.
REQ-034 Buffer full, then iq_pop=1 for one cycle:
- Next request to 0x70 asserts the following cycle.
- The entry is pushed at the tail without loss.
REQ-035 flush=1, flush_pc=0x200 while a request to 0x68 is pending with resp delayed 3 cycles:
- Address 0x68 is held.
- The resp data is discarded.
- The next request goes to 0x200.
- iq_valid=0 until the 0x200 resp.
REQ-036 Simultaneous resp, iq_pop and 2 valid entries: the count stays 2, the head advances, and the new tail pc is correct.
REQ-037 reset_n=0 mid-request, released, then a stale resp pulse: no push; fetch restarts at 0x60.
REQ-038 flush_pc=0xFFFFFFFC, then 2 fetches: addresses are 0xFFFFFFFC and 0x00000000.
